// File: rtl/nios_qsys_div_cell.sv
// nios_qsys_div_cell
// Sequential 32-bit integer divide cell (div / divu) for the Nios II custom
// datapath. It uses radix-2 restoring division on operand magnitudes. The
// cell takes 32 iteration cycles, then one fix-up cycle for sign correction
// and divide-by-zero handling.
//
// Ports:
//   clk                  : single clock, rising edge
//   reset_n              : synchronous active-low reset
//   A_div_start          : request, accepted only while idle
//   A_div_signed         : 1 = two's-complement operands, sampled with start
//   A_div_src1           : dividend, sampled with start
//   A_div_src2           : divisor, sampled with start
//   A_div_busy           : high from the cycle after acceptance through FIX
//   A_div_done           : one-cycle pulse, results valid in that cycle
//   A_div_cell_result    : quotient, held until the next done
//   A_div_cell_remainder : remainder, held until the next done
module nios_qsys_div_cell (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        A_div_start,
  input  logic        A_div_signed,
  input  logic [31:0] A_div_src1,
  input  logic [31:0] A_div_src2,
  output logic        A_div_busy,
  output logic        A_div_done,
  output logic [31:0] A_div_cell_result,
  output logic [31:0] A_div_cell_remainder
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_e;

  state_e      state_q;
  logic [4:0]  cnt_q;
  logic [31:0] rem_q;     // partial remainder
  logic [31:0] quo_q;     // dividend magnitude shifting out, quotient shifting in
  logic [31:0] dvs_q;     // divisor magnitude
  logic [31:0] src1_q;    // original dividend, returned as remainder on div0
  logic        qneg_q;
  logic        rneg_q;
  logic        div0_q;
  logic        busy_q;
  logic        done_q;
  logic [31:0] res_q;
  logic [31:0] remo_q;

  logic [31:0] mag1_d;
  logic [31:0] mag2_d;
  logic [32:0] shift_d;
  logic        ge_d;
  logic [31:0] rem_d;
  logic [31:0] quo_d;
  logic [31:0] fix_quo_d;
  logic [31:0] fix_rem_d;

  // Operand magnitudes and one restoring step, plus the final sign fix-up.
  always_comb begin
    mag1_d    = (A_div_signed && A_div_src1[31]) ? (32'd0 - A_div_src1) : A_div_src1;
    mag2_d    = (A_div_signed && A_div_src2[31]) ? (32'd0 - A_div_src2) : A_div_src2;
    // Shift {rem, quo} left by one; the 33-bit value is the trial minuend.
    shift_d   = {rem_q, quo_q[31]};
    ge_d      = (shift_d >= {1'b0, dvs_q});
    // When the trial is non-negative the difference is below 2^32, so a
    // 32-bit subtraction is exact.
    rem_d     = ge_d ? (shift_d[31:0] - dvs_q) : shift_d[31:0];
    quo_d     = {quo_q[30:0], ge_d};
    fix_quo_d = qneg_q ? (32'd0 - quo_q) : quo_q;
    fix_rem_d = rneg_q ? (32'd0 - rem_q) : rem_q;
  end

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 5'd0;
      rem_q   <= 32'd0;
      quo_q   <= 32'd0;
      dvs_q   <= 32'd0;
      src1_q  <= 32'd0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      div0_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      res_q   <= 32'd0;
      remo_q  <= 32'd0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (A_div_start) begin
            state_q <= S_RUN;
            cnt_q   <= 5'd0;
            rem_q   <= 32'd0;
            quo_q   <= mag1_d;
            dvs_q   <= mag2_d;
            src1_q  <= A_div_src1;
            qneg_q  <= A_div_signed & (A_div_src1[31] ^ A_div_src2[31]);
            rneg_q  <= A_div_signed & A_div_src1[31];
            div0_q  <= (A_div_src2 == 32'd0);
            busy_q  <= 1'b1;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_RUN: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_q <= S_FIX;
          end else begin
            state_q <= S_RUN;
          end
        end
        S_FIX: begin
          // Divide by zero overrides the sign fix-up.
          if (div0_q) begin
            res_q  <= 32'hFFFF_FFFF;
            remo_q <= src1_q;
          end else begin
            res_q  <= fix_quo_d;
            remo_q <= fix_rem_d;
          end
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          cnt_q   <= 5'd0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          cnt_q   <= 5'd0;
        end
      endcase
    end
  end

  assign A_div_busy           = busy_q;
  assign A_div_done           = done_q;
  assign A_div_cell_result    = res_q;
  assign A_div_cell_remainder = remo_q;

endmodule

// File: tb/tb_nios_qsys_div_cell.sv
// Self-checking bench for nios_qsys_div_cell. A cycle-level model predicts
// busy/done/result/remainder from the handshake rules and plain integer
// arithmetic. Directed cases also pin literal expected values.
module tb_nios_qsys_div_cell;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic        sgn;
  logic [31:0] src1;
  logic [31:0] src2;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [31:0] remainder;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  nios_qsys_div_cell dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .A_div_start         (start),
    .A_div_signed        (sgn),
    .A_div_src1          (src1),
    .A_div_src2          (src2),
    .A_div_busy          (busy),
    .A_div_done          (done),
    .A_div_cell_result   (result),
    .A_div_cell_remainder(remainder)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at t=%0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
    end
  endtask

  // Reference divide: 64-bit integer arithmetic, truncating toward zero.
  function automatic void ref_div(input bit sg, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r);
    longint sa, sb, tq, tr;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else begin
      sa = sg ? longint'($signed(a)) : longint'({32'd0, a});
      sb = sg ? longint'($signed(b)) : longint'({32'd0, b});
      tq = sa / sb;
      tr = sa % sb;
      q  = tq[31:0];
      r  = tr[31:0];
    end
  endfunction

  // Cycle model: cyc is the index of the current cycle.
  int          cyc = 0;
  bit          pend = 1'b0;
  int          acc_cyc = 0;
  int          done_cyc = 0;
  logic [31:0] pq, pr;
  logic [31:0] m_res = 32'd0;
  logic [31:0] m_rem = 32'd0;

  always @(posedge clk) begin
    if (!reset_n) begin
      pend  = 1'b0;
      m_res = 32'd0;
      m_rem = 32'd0;
    end else if (start && (!pend || cyc >= done_cyc)) begin
      pend     = 1'b1;
      acc_cyc  = cyc;
      done_cyc = cyc + 34;
      ref_div(sgn, src1, src2, pq, pr);
    end
    cyc++;
    if (pend && cyc == done_cyc) begin
      m_res = pq;
      m_rem = pr;
    end
  end

  // Per-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", {31'd0, busy}, {31'd0, pend && cyc > acc_cyc && cyc < done_cyc});
      chk("done", {31'd0, done}, {31'd0, pend && cyc == done_cyc});
      chk("result", result, m_res);
      chk("remainder", remainder, m_rem);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input bit sg, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    sgn   = sg;
    src1  = a;
    src2  = b;
  endtask

  task automatic scramble();
    start = 1'b0;
    sgn   = $urandom_range(1, 0);
    src1  = $urandom;
    src2  = $urandom;
  endtask

  // Start in the current cycle (cycle 0), finish in cycle 34 with literal checks.
  task automatic do_op(input bit sg, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eq, input logic [31:0] er);
    set_op(sg, a, b);
    tick();
    scramble();
    @(negedge clk);
    chk("busy_c1", {31'd0, busy}, 32'd1);
    repeat (33) tick();
    @(negedge clk);
    chk("done_c34", {31'd0, done}, 32'd1);
    chk("busy_c34", {31'd0, busy}, 32'd0);
    chk("lit_result", result, eq);
    chk("lit_remainder", remainder, er);
  endtask

  logic [31:0] eq, er, ra, rb;
  bit          rs;

  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    sgn     = 1'b0;
    src1    = 32'd0;
    src2    = 32'd0;
    repeat (3) tick();
    chk_en  = 1'b1;
    @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_remainder", remainder, 32'd0);
    reset_n = 1'b1;
    tick();

    do_op(1'b0, 32'd100, 32'd7, 32'h0000_000E, 32'h0000_0002);
    do_op(1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    do_op(1'b1, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h0000_0001);
    do_op(1'b0, 32'hFFFF_FFF9, 32'h0000_0002, 32'h7FFF_FFFC, 32'h0000_0001);
    do_op(1'b1, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678);
    do_op(1'b0, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678);
    do_op(1'b1, 32'h8000_0005, 32'd0, 32'hFFFF_FFFF, 32'h8000_0005);
    do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000);
    do_op(1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'h0000_000E, 32'hFFFF_FFFE);
    tick();

    // Starts while busy must be ignored.
    set_op(1'b0, 32'd100, 32'd7);
    for (int c = 1; c <= 34; c++) begin
      tick();
      if (c == 5 || c == 20) set_op(1'b1, 32'h0000_1000, 32'h0000_0003);
      else scramble();
    end
    @(negedge clk);
    chk("ign_done", {31'd0, done}, 32'd1);
    chk("ign_result", result, 32'h0000_000E);
    chk("ign_remainder", remainder, 32'h0000_0002);
    tick();

    // Reset mid-operation, then restart right after reset.
    set_op(1'b1, 32'hFFFF_FFF9, 32'h0000_0002);
    for (int c = 1; c <= 16; c++) begin
      tick();
      if (c == 15) begin
        scramble();
        reset_n = 1'b0;
        start   = 1'b1;
      end else if (c == 16) begin
        reset_n = 1'b1;
        set_op(1'b0, 32'd100, 32'd7);
      end else begin
        scramble();
      end
    end
    @(negedge clk);
    chk("rst16_busy", {31'd0, busy}, 32'd0);
    chk("rst16_result", result, 32'd0);
    tick();
    scramble();
    repeat (33) tick();
    @(negedge clk);
    chk("rst50_done", {31'd0, done}, 32'd1);
    chk("rst50_result", result, 32'h0000_000E);
    chk("rst50_remainder", remainder, 32'h0000_0002);
    tick();

    // Back-to-back: second start in the done cycle of the first.
    do_op(1'b0, 32'd100, 32'd7, 32'h0000_000E, 32'h0000_0002);
    do_op(1'b0, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0FFF_FFFF, 32'h0000_000F);

    // Random operands, checked against the reference divide.
    for (int i = 0; i < 6; i++) begin
      rs = $urandom_range(1, 0);
      ra = $urandom;
      rb = (i == 3) ? 32'd0 : ($urandom >> $urandom_range(30, 0));
      ref_div(rs, ra, rb, eq, er);
      do_op(rs, ra, rb, eq, er);
    end
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/nios_qsys_div_cell.md
# nios_qsys_div_cell

Sequential 32-bit integer divide cell for the Nios II custom datapath; it is the inverse-operation companion to the pipelined multiply cell. It takes a dividend and divisor, runs a radix-2 restoring division on operand magnitudes over 32 iteration cycles, applies sign correction, and returns quotient and remainder with a start/done handshake. It serves both `div` (signed) and `divu` (unsigned).

## Interface
- No parameters; width fixed at 32.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset_n`  in  1  reset, synchronous and active-low.
- `A_div_start`  in  1  request; accepted only in IDLE.
- `A_div_signed`  in  1  1 = two's-complement operands, 0 = unsigned; sampled with start.
- `A_div_src1`  in  32  dividend; sampled with start.
- `A_div_src2`  in  32  divisor; sampled with start.
- `A_div_busy`  out  1  high from the cycle after acceptance through the FIX cycle.
- `A_div_done`  out  1  one-cycle pulse; results valid in that cycle.
- `A_div_cell_result`  out  32  quotient, held until the next done.
- `A_div_cell_remainder`  out  32  remainder, held until the next done.

## Operation
- States: IDLE, RUN, FIX.
  - IDLE + start → RUN. Latch `|src1|` and `|src2|` (magnitudes only when signed; raw values when unsigned). Latch the quotient-negate flag (sign1 XOR sign2), the remainder-negate flag (sign1), and div0 (src2 == 0). Clear the partial remainder. Set step count to 0.
  - RUN: one restoring step per cycle.
    - Shift `{rem, quo}` left by 1.
    - Trial-subtract the divisor from the 33-bit partial remainder.
    - If the result is non-negative, keep it and set the quotient LSB to 1.
    - After step 31 → FIX.
  - FIX: apply corrections, register both outputs, pulse done, → IDLE.
- Sign rules (signed mode):
  - Quotient truncates toward zero.
  - Remainder takes the sign of the dividend.
  - Negate a magnitude by two's complement, mod 2^32.
- Divide by zero (either mode): quotient = 0xFFFFFFFF, remainder = original src1. This is forced in FIX and overrides the sign fix-up.
- Signed overflow 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0. This falls out naturally from magnitude arithmetic with a 32-bit wrap, so no special case is needed.
- Start asserted while busy (RUN or FIX) is ignored. Operands are not re-sampled and there is no queueing.
- Start in the same cycle as done is accepted, because the state is IDLE in that cycle.
- Inputs may change freely after the acceptance cycle.

## Timing
- Reset (synchronous, `reset_n` low at an edge):
  - State → IDLE.
  - `A_div_busy` = 0, `A_div_done` = 0, `A_div_cell_result` = 0, `A_div_cell_remainder` = 0.
  - Step count 0.
- Reset mid-operation aborts the divide with no done pulse. Start is ignored during any cycle in which `reset_n` is low.
- Cycle numbering, with start high in IDLE during cycle 0:
  - Acceptance edge at the end of cycle 0.
  - RUN occupies cycles 1–32: 32 steps.
  - FIX occupies cycle 33.
  - `A_div_done` = 1 and new results are visible in cycle 34.
- Latency from start to done is therefore 34 cycles.
- Busy is high in cycles 1–33 and low in cycle 34.
- Done is high for exactly one cycle per accepted start.
- Minimum issue interval is 34 cycles (a back-to-back start in the done cycle).
- Outputs change only on the edge that raises done, or on reset.

## Test plan
- Unsigned 100 / 7, start in cycle 0 → done in cycle 34 only; result 0x0000000E, remainder 0x00000002; busy high in cycles 1–33.
- Signed −7 / 2 (0xFFFFFFF9 / 0x00000002) → 0xFFFFFFFD, remainder 0xFFFFFFFF. Signed 7 / −2 → 0xFFFFFFFD, remainder 0x00000001. Unsigned 0xFFFFFFF9 / 2 → 0x7FFFFFFC, remainder 1.
- Divide by zero: 0x12345678 / 0, signed and unsigned → result 0xFFFFFFFF, remainder 0x12345678. Signed 0x80000000 / 0xFFFFFFFF → 0x80000000, remainder 0.
- Start pulsed with different operands in cycles 5 and 20 of a running divide → ignored; only the original result appears, in cycle 34; exactly one done.
- `reset_n` low in cycle 15, high from cycle 16 → busy 0 from cycle 16, no done pulse, outputs 0. A new start in cycle 16 (100 / 7) → done in cycle 50 with 14 r 2.
- Back-to-back: start 100 / 7 in cycle 0, then start 0xFFFFFFFF / 0x10 in cycle 34 (the done cycle) → accepted; second done in cycle 68 with 0x0FFFFFFF r 0xF. First results are held through cycles 34–67.
